// File: rtl/mips32_pipe_core.sv
// Five-stage MIPS32-subset pipeline (IF/ID/EX/MEM/WB) with a unified word-addressed memory.
// EX forwarding and a one-cycle load-use interlock keep every instruction sequence hazard-safe.
module mips32_pipe_core #(
  parameter int MEM_WORDS = 1024,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [5:0] OP_ADD   = 6'b000000, OP_SUB  = 6'b000001, OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011, OP_SLT  = 6'b000100, OP_MUL  = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000, OP_SW   = 6'b001001, OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110, OP_HLT  = 6'b111111;

  logic [31:0] mem  [0:MEM_WORDS-1];
  logic [31:0] regs [0:31];

  logic              halted_reg, fetch_stop_reg;
  logic [ADDR_W-1:0] pc_reg;

  logic              ifid_valid_reg;
  logic [31:0]       ifid_ir_reg;
  logic [ADDR_W-1:0] ifid_pc_reg;

  logic              idex_valid_reg, idex_wr_reg;
  logic [5:0]        idex_op_reg;
  logic [1:0][4:0]   idex_src_reg;
  logic [1:0][31:0]  idex_val_reg;
  logic [31:0]       idex_imm_reg;
  logic [ADDR_W-1:0] idex_pc_reg;
  logic [4:0]        idex_dest_reg;

  logic              exmem_valid_reg, exmem_wr_reg, exmem_lw_reg, exmem_sw_reg, exmem_hlt_reg;
  logic [4:0]        exmem_dest_reg;
  logic [31:0]       exmem_alu_reg, exmem_sdata_reg;

  logic              memwb_valid_reg, memwb_wr_reg, memwb_hlt_reg;
  logic [4:0]        memwb_dest_reg;
  logic [31:0]       memwb_val_reg;

  assign halted = halted_reg;
  assign pc     = pc_reg;

  // ID decode
  logic [5:0]       id_op;
  logic [4:0]       id_rd, id_dest;
  logic [31:0]      id_imm;
  logic             id_is_r, id_is_i, id_wr, id_uses_rt, id_hlt, load_use;
  logic [1:0][4:0]  id_src;
  logic [1:0][31:0] id_val, ex_opnd;
  logic             wb_we;

  assign id_op      = ifid_ir_reg[31:26];
  assign id_src[0]  = ifid_ir_reg[25:21];
  assign id_src[1]  = ifid_ir_reg[20:16];
  assign id_rd      = ifid_ir_reg[15:11];
  assign id_imm     = {{16{ifid_ir_reg[15]}}, ifid_ir_reg[15:0]};
  assign id_is_r    = (id_op <= OP_MUL);
  assign id_is_i    = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
  assign id_wr      = id_is_r || id_is_i || (id_op == OP_LW);
  assign id_dest    = id_is_r ? id_rd : id_src[1];
  assign id_uses_rt = id_is_r || (id_op == OP_SW);
  assign id_hlt     = ifid_valid_reg && (id_op == OP_HLT);

  assign wb_we = memwb_valid_reg && memwb_wr_reg && (memwb_dest_reg != 5'd0);

  // Stall one cycle when ID consumes the destination of a load currently in EX.
  assign load_use = idex_valid_reg && (idex_op_reg == OP_LW) && (idex_dest_reg != 5'd0) &&
                    ifid_valid_reg && ((id_src[0] == idex_dest_reg) ||
                                       (id_uses_rt && id_src[1] == idex_dest_reg));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // Register read sees a same-cycle writeback; EX prefers the younger EX/MEM result.
      assign id_val[gi] = (id_src[gi] == 5'd0) ? 32'd0 :
                          (wb_we && memwb_dest_reg == id_src[gi]) ? memwb_val_reg :
                          regs[id_src[gi]];
      assign ex_opnd[gi] = (exmem_valid_reg && exmem_wr_reg && !exmem_lw_reg &&
                            exmem_dest_reg != 5'd0 && exmem_dest_reg == idex_src_reg[gi]) ? exmem_alu_reg :
                           (wb_we && memwb_dest_reg == idex_src_reg[gi]) ? memwb_val_reg :
                           idex_val_reg[gi];
    end
  endgenerate

  // EX stage
  logic [31:0]       ex_alu;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;

  always_comb begin
    ex_alu = 32'd0;
    case (idex_op_reg)
      OP_ADD:               ex_alu = ex_opnd[0] + ex_opnd[1];
      OP_SUB:               ex_alu = ex_opnd[0] - ex_opnd[1];
      OP_AND:               ex_alu = ex_opnd[0] & ex_opnd[1];
      OP_OR:                ex_alu = ex_opnd[0] | ex_opnd[1];
      OP_SLT:               ex_alu = {31'd0, $signed(ex_opnd[0]) < $signed(ex_opnd[1])};
      OP_MUL:               ex_alu = ex_opnd[0] * ex_opnd[1];
      OP_ADDI, OP_LW, OP_SW: ex_alu = ex_opnd[0] + idex_imm_reg;
      OP_SUBI:              ex_alu = ex_opnd[0] - idex_imm_reg;
      OP_SLTI:              ex_alu = {31'd0, $signed(ex_opnd[0]) < $signed(idex_imm_reg)};
      default:              ex_alu = 32'd0;
    endcase
  end

  assign ex_taken  = idex_valid_reg && (((idex_op_reg == OP_BEQZ)  && (ex_opnd[0] == 32'd0)) ||
                                        ((idex_op_reg == OP_BNEQZ) && (ex_opnd[0] != 32'd0)));
  assign ex_target = idex_pc_reg + ADDR_W'(1) + idex_imm_reg[ADDR_W-1:0];

  logic [31:0] mem_rdata;
  assign mem_rdata = mem[exmem_alu_reg[ADDR_W-1:0]];

  // Architectural storage is not reset so preloaded programs and data survive rst_n.
  always @(posedge clk) begin
    if (!halted_reg) begin
      if (exmem_valid_reg && exmem_sw_reg) mem[exmem_alu_reg[ADDR_W-1:0]] <= exmem_sdata_reg;
      if (wb_we) regs[memwb_dest_reg] <= memwb_val_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted_reg      <= 1'b0;
      fetch_stop_reg  <= 1'b0;
      pc_reg          <= '0;
      ifid_valid_reg  <= 1'b0;
      ifid_ir_reg     <= '0;
      ifid_pc_reg     <= '0;
      idex_valid_reg  <= 1'b0;
      idex_wr_reg     <= 1'b0;
      idex_op_reg     <= '0;
      idex_src_reg    <= '0;
      idex_val_reg    <= '0;
      idex_imm_reg    <= '0;
      idex_pc_reg     <= '0;
      idex_dest_reg   <= '0;
      exmem_valid_reg <= 1'b0;
      exmem_wr_reg    <= 1'b0;
      exmem_lw_reg    <= 1'b0;
      exmem_sw_reg    <= 1'b0;
      exmem_hlt_reg   <= 1'b0;
      exmem_dest_reg  <= '0;
      exmem_alu_reg   <= '0;
      exmem_sdata_reg <= '0;
      memwb_valid_reg <= 1'b0;
      memwb_wr_reg    <= 1'b0;
      memwb_hlt_reg   <= 1'b0;
      memwb_dest_reg  <= '0;
      memwb_val_reg   <= '0;
    end else if (!halted_reg) begin
      if (ex_taken)
        pc_reg <= ex_target;
      else if (!(load_use || id_hlt || fetch_stop_reg))
        pc_reg <= pc_reg + ADDR_W'(1);
      if (id_hlt && !ex_taken) fetch_stop_reg <= 1'b1;

      if (ex_taken || ((id_hlt || fetch_stop_reg) && !load_use)) begin
        ifid_valid_reg <= 1'b0;
      end else if (!load_use) begin
        ifid_valid_reg <= 1'b1;
        ifid_ir_reg    <= mem[pc_reg];
        ifid_pc_reg    <= pc_reg;
      end

      idex_valid_reg <= ifid_valid_reg && !ex_taken && !load_use;
      idex_wr_reg    <= id_wr;
      idex_op_reg    <= id_op;
      idex_src_reg   <= id_src;
      idex_val_reg   <= id_val;
      idex_imm_reg   <= id_imm;
      idex_pc_reg    <= ifid_pc_reg;
      idex_dest_reg  <= id_dest;

      exmem_valid_reg <= idex_valid_reg;
      exmem_wr_reg    <= idex_wr_reg;
      exmem_lw_reg    <= (idex_op_reg == OP_LW);
      exmem_sw_reg    <= (idex_op_reg == OP_SW);
      exmem_hlt_reg   <= (idex_op_reg == OP_HLT);
      exmem_dest_reg  <= idex_dest_reg;
      exmem_alu_reg   <= ex_alu;
      exmem_sdata_reg <= ex_opnd[1];

      memwb_valid_reg <= exmem_valid_reg;
      memwb_wr_reg    <= exmem_wr_reg;
      memwb_hlt_reg   <= exmem_hlt_reg;
      memwb_dest_reg  <= exmem_dest_reg;
      memwb_val_reg   <= exmem_lw_reg ? mem_rdata : exmem_alu_reg;

      if (memwb_valid_reg && memwb_hlt_reg) halted_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips32_pipe_core.sv
// Directed programs for mips32_pipe_core; expectations are queued when a program is issued
// and a separate monitor compares them once the core reports halted (or immediately for reset checks).
module tb_mips32_pipe_core;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halted;
  logic [AW-1:0] pc;

  mips32_pipe_core dut (.clk(clk), .rst_n(rst_n), .halted(halted), .pc(pc));

  always #5 clk = ~clk;

  typedef enum int {K_REG, K_MEM, K_PC, K_HALT} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    int          idx;
    logic [31:0] exp;
    bit          now;
  } chk_t;

  chk_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010, OR_ = 6'b000011;
  localparam logic [5:0] SLT = 6'b000100, MUL = 6'b000101, ADDI = 6'b001010, SUBI = 6'b001011;
  localparam logic [5:0] SLTI = 6'b001100, BNEQZ = 6'b001101, BEQZ = 6'b001110;
  localparam logic [31:0] HLT = 32'hfc000000;

  function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rd, rs, rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt, rs,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic expect_v(input string name, input kind_e kind, input int idx,
                          input logic [31:0] exp, input bit now);
    chk_t c;
    c.name = name; c.kind = kind; c.idx = idx; c.exp = exp; c.now = now;
    exp_q.push_back(c);
  endtask

  // Monitor: pops expectations whenever the core presents its result.
  initial begin
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && (exp_q[0].now || halted === 1'b1)) begin
        chk_t        c;
        logic [31:0] act;
        c = exp_q.pop_front();
        case (c.kind)
          K_REG:   act = dut.regs[c.idx];
          K_MEM:   act = dut.mem[c.idx];
          K_PC:    act = 32'(pc);
          default: act = {31'd0, halted};
        endcase
        checks++;
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end else begin
          $display("ok   %s = %h", c.name, act);
        end
      end
    end
  end

  task automatic wait_drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      foreach (exp_q[i]) begin
        checks++;
        errors++;
        $display("FAIL %s timeout: %s not observed within %0d cycles", tag, exp_q[i].name, budget);
      end
      exp_q.delete();
    end
  endtask

  task automatic reset_preload();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 32; k++) dut.regs[k] = 32'(k);
    for (int a = 0; a < 1024; a++) dut.mem[a] = 32'd0;
    dut.mem[120] = 32'd85;
  endtask

  task automatic put(input int a, input logic [31:0] w);
    dut.mem[a] = w;
  endtask

  task automatic load_padded();
    put(0, 32'h28010078); put(1, 32'h0c631800); put(2, 32'h20220000); put(3, 32'h0c631800);
    put(4, 32'h2842002d); put(5, 32'h0c631800); put(6, 32'h24220001); put(7, 32'hfc000000);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Padded load/store program and reset state
    reset_preload();
    load_padded();
    @(negedge clk);
    expect_v("reset halted", K_HALT, 0, 32'd0, 1'b1);
    expect_v("reset pc", K_PC, 0, 32'd0, 1'b1);
    wait_drain(4, "reset");
    expect_v("pad mem[121]", K_MEM, 121, 32'd130, 1'b0);
    expect_v("pad r1", K_REG, 1, 32'd120, 1'b0);
    expect_v("pad r2", K_REG, 2, 32'd130, 1'b0);
    expect_v("pad r3", K_REG, 3, 32'd3, 1'b0);
    release_reset();
    wait_drain(15, "padded");

    // Same program without padding: forwarding plus load-use stall
    reset_preload();
    put(0, 32'h28010078); put(1, 32'h20220000); put(2, 32'h2842002d);
    put(3, 32'h24220001); put(4, HLT);
    expect_v("fwd mem[121]", K_MEM, 121, 32'd130, 1'b0);
    expect_v("fwd r1", K_REG, 1, 32'd120, 1'b0);
    expect_v("fwd r2", K_REG, 2, 32'd130, 1'b0);
    release_reset();
    wait_drain(12, "forward");

    // ALU operations
    reset_preload();
    put(0, r_ins(ADD, 5, 1, 2));
    put(1, r_ins(SUB, 6, 1, 2));
    put(2, r_ins(SLT, 7, 6, 0));
    put(3, r_ins(MUL, 8, 3, 4));
    put(4, i_ins(SUBI, 9, 0, 16'd1));
    put(5, r_ins(OR_, 10, 8, 1));
    put(6, r_ins(AND_, 11, 12, 13));
    put(7, i_ins(SLTI, 13, 9, 16'hfffb));
    put(8, HLT);
    expect_v("alu add r5", K_REG, 5, 32'd3, 1'b0);
    expect_v("alu sub r6", K_REG, 6, 32'hffffffff, 1'b0);
    expect_v("alu slt r7", K_REG, 7, 32'd1, 1'b0);
    expect_v("alu mul r8", K_REG, 8, 32'd12, 1'b0);
    expect_v("alu subi r9", K_REG, 9, 32'hffffffff, 1'b0);
    expect_v("alu or r10", K_REG, 10, 32'd13, 1'b0);
    expect_v("alu and r11", K_REG, 11, 32'd12, 1'b0);
    expect_v("alu slti r13", K_REG, 13, 32'd0, 1'b0);
    release_reset();
    wait_drain(30, "alu");

    // Countdown loop, then a taken BEQZ skipping one instruction
    reset_preload();
    put(0, i_ins(ADDI, 1, 0, 16'd3));
    put(1, i_ins(SUBI, 1, 1, 16'd1));
    put(2, i_ins(BNEQZ, 0, 1, 16'hfffe));
    put(3, i_ins(ADDI, 4, 0, 16'd7));
    put(4, i_ins(ADDI, 5, 5, 16'd1));
    put(5, i_ins(BEQZ, 0, 0, 16'd1));
    put(6, i_ins(ADDI, 6, 0, 16'd99));
    put(7, HLT);
    expect_v("loop r1", K_REG, 1, 32'd0, 1'b0);
    expect_v("loop r4", K_REG, 4, 32'd7, 1'b0);
    expect_v("loop r5 once", K_REG, 5, 32'd6, 1'b0);
    expect_v("beqz skip r6", K_REG, 6, 32'd6, 1'b0);
    release_reset();
    wait_drain(40, "loop");

    // R0 write ignored; nothing after HLT executes; halted and pc stay frozen
    reset_preload();
    put(0, i_ins(ADDI, 0, 0, 16'd5));
    put(1, HLT);
    put(2, i_ins(ADDI, 3, 0, 16'd9));
    expect_v("r0 stays zero", K_REG, 0, 32'd0, 1'b0);
    release_reset();
    wait_drain(10, "r0");
    repeat (20) @(posedge clk);
    expect_v("halt sticky", K_HALT, 0, 32'd1, 1'b1);
    expect_v("halt pc frozen", K_PC, 0, 32'd2, 1'b1);
    expect_v("halt r3 unchanged", K_REG, 3, 32'd3, 1'b1);
    wait_drain(3, "halt");

    // Asynchronous reset mid-run, then a full rerun
    reset_preload();
    load_padded();
    put(121, 32'd0);
    release_reset();
    repeat (5) @(posedge clk);
    expect_v("midrun pc", K_PC, 0, 32'd5, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    expect_v("async halted", K_HALT, 0, 32'd0, 1'b1);
    expect_v("async pc", K_PC, 0, 32'd0, 1'b1);
    wait_drain(2, "async");
    expect_v("rerun mem[121]", K_MEM, 121, 32'd130, 1'b0);
    expect_v("rerun r2", K_REG, 2, 32'd130, 1'b0);
    release_reset();
    wait_drain(15, "rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
